conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter FEATURE_MAP_WIDTH, default 64, output map width in pixels.
REQ-002 SHALL have parameter FEATURE_MAP_HEIGHT, default 64, output map height in pixels.
REQ-003 SHALL have parameter INPUT_NB_CHANNELS, default 4, input channels per tap.
REQ-004 SHALL have parameter OUTPUT_NB_CHANNELS, default 32, output channels.
REQ-005 SHALL have parameter KERNEL_SIZE, default 3, odd square kernel side.
REQ-006 SHALL have parameter MAC_LATENCY, default 1, cycles from last mac_valid to result available.
REQ-007 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  sole clock, rising edge.
- arst_n_in  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request.
- running  out  1  high from the cycle after an accepted start until return to IDLE.
- con_valid  in  1  external word valid on con buses.
- con_ready  out  1  sequencer accepts a word this cycle.
- driving_cons  out  1  DUT owns con buses (output phase).
- last_load_K  out  1  final kernel word of the current channel accepted this cycle.
- k_we  out  1  kernel buffer write strobe.
- k_addr  out  clog2(K*K*IN_CH)  kernel buffer address, used for write and tap read.
- mac_valid  out  1  datapath accumulates this cycle.
- mac_clear  out  1  first tap of a pixel; accumulator is loaded, not added.
- pad  out  1  tap outside map; datapath uses zero input.
- output_valid  out  1  result for (output_x, output_y, output_ch) is on the con buses.
- output_x  out  clog2(FM_W)  pixel column.
- output_y  out  clog2(FM_H)  pixel row.
- output_ch  out  clog2(OUT_CH)  output channel.

Function
REQ-008 SHALL implement states IDLE, LOAD_K, TAP, DRAIN, OUT, DONE.
REQ-009 IDLE: start=1 SHALL go to LOAD_K with ch=0; start outside IDLE SHALL be ignored.
REQ-010 LOAD_K: con_ready=1; each cycle with con_valid=1 SHALL assert k_we with k_addr=0..K*K*IN_CH-1 in order; on the last word, assert last_load_K, clear y and x, and go to TAP.
REQ-011 TAP loop order SHALL be ky (outer), kx, ci (inner); k_addr=(ky*K+kx)*IN_CH+ci.
REQ-012 TAP coordinate SHALL be ix=x+kx-(K-1)/2 and iy=y+ky-(K-1)/2; out of range means ix<0, ix>=FM_W, iy<0 or iy>=FM_H.
REQ-013 In-range tap: con_ready=1; the tap SHALL advance only on con_valid=1, with mac_valid=1 in that cycle.
REQ-014 Out-of-range tap: con_ready=0, pad=1, mac_valid=1; the tap SHALL advance unconditionally in that cycle.
REQ-015 mac_clear SHALL equal mac_valid on tap (0,0,0) and be 0 on all other taps.
REQ-016 After the last tap, the sequencer SHALL enter DRAIN for MAC_LATENCY-1 cycles (skipped when MAC_LATENCY=1), then OUT.
REQ-017 OUT SHALL last exactly one cycle, with output_valid=1, driving_cons=1, con_ready=0 and x/y/ch stable; there is no backpressure.
REQ-018 After OUT, the sequencer SHALL advance x, wrapping to y+1, and go to TAP.
- After the last pixel, it SHALL advance ch and go to LOAD_K.
- After the last channel, it SHALL go to DONE.
REQ-019 DONE SHALL last one cycle, then go to IDLE; running SHALL be 0 in IDLE.
REQ-020 Counters SHALL wrap only at their parameter bound; no arithmetic beyond compares and increments is needed.
REQ-021 con_valid SHALL be ignored whenever con_ready=0.
REQ-022 Outputs not named in a state's rule SHALL be 0 in that state.

Reset
REQ-023 arst_n_in=0 SHALL immediately force IDLE, clear all counters, and drive every output to 0, including mid-run.
REQ-024 After reset release, start SHALL be accepted on the first clock edge.

Structure
REQ-025 A shared package SHALL hold the state enum and the derived widths (KW_COUNT=K*K*IN_CH and the address, x, y and ch widths).
REQ-026 A single sub-module, conv_idx_counter (parameterized wrapping counter with en, wrap flag), SHALL be instanced per loop index.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset asserted mid-TAP -> all outputs 0 in the same cycle; running=0; state IDLE.
- start, con_valid held 1 -> 36 k_we cycles, k_addr 0..35, last_load_K only on cycle 36, then TAP.
- Pixel (0,0) with defaults -> 20 pad taps and 16 handshaked taps; mac_clear on the first tap only; output_valid one cycle later with x=0, y=0, ch=0.
- con_valid toggling 1,0 during interior pixel (5,5) -> 36 accepted taps over 72 cycles; no pad; exactly one output_valid.
- Full run with con_valid=1 -> 131072 output_valid pulses; the last is (63,63,31); 32 last_load_K pulses; running falls 2 cycles after the final OUT.
- start pulsed during TAP, plus MAC_LATENCY=3 -> start ignored; OUT occurs 3 cycles after the last mac_valid.

Source files
------------

// File: rtl/conv_sequencer_pkg.sv
// Shared types and width helpers for the convolution sequencer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package conv_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_K,
      TAP,
      DRAIN,
      OUT,
      DONE
   } state_t;

   // Index width for a counter spanning 0..n-1; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_FM_W   = 64;
   localparam int DEF_FM_H   = 64;
   localparam int DEF_IN_CH  = 4;
   localparam int DEF_OUT_CH = 32;
   localparam int DEF_K      = 3;
   localparam int DEF_MAC_L  = 1;

   // Derived widths for the default geometry.
   localparam int KW_COUNT = DEF_K * DEF_K * DEF_IN_CH;
   localparam int KADDR_W  = idx_w(KW_COUNT);
   localparam int X_W      = idx_w(DEF_FM_W);
   localparam int Y_W      = idx_w(DEF_FM_H);
   localparam int CH_W     = idx_w(DEF_OUT_CH);

endpackage

// File: rtl/conv_idx_counter.sv
// Wrapping loop index counter 0..N-1 with synchronous clear and enable.
// Latency: count updates on the clock edge after en; wrap is combinational.
// Backpressure: none; advances only when en is high.
module conv_idx_counter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         arst_n_in,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   logic last;

   assign last = (cnt == W'(N - 1));
   assign wrap = en & last;

   // Count up on enable, returning to zero after the final index.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: kernel load, tap walk with padding, drain and result slot per pixel/channel.
// Latency: OUT follows the last tap by MAC_LATENCY cycles; one OUT cycle per pixel per output channel.
// Backpressure: in-range taps and kernel words stall on con_valid; pad taps and OUT never stall.
module conv_sequencer
   import conv_sequencer_pkg::*;
#(
   parameter int FEATURE_MAP_WIDTH  = DEF_FM_W,
   parameter int FEATURE_MAP_HEIGHT = DEF_FM_H,
   parameter int INPUT_NB_CHANNELS  = DEF_IN_CH,
   parameter int OUTPUT_NB_CHANNELS = DEF_OUT_CH,
   parameter int KERNEL_SIZE        = DEF_K,
   parameter int MAC_LATENCY        = DEF_MAC_L
) (
   input  logic clk,
   input  logic arst_n_in,
   input  logic start,
   output logic running,
   input  logic con_valid,
   output logic con_ready,
   output logic driving_cons,
   output logic last_load_K,
   output logic k_we,
   output logic [idx_w(KERNEL_SIZE*KERNEL_SIZE*INPUT_NB_CHANNELS)-1:0] k_addr,
   output logic mac_valid,
   output logic mac_clear,
   output logic pad,
   output logic output_valid,
   output logic [idx_w(FEATURE_MAP_WIDTH)-1:0]  output_x,
   output logic [idx_w(FEATURE_MAP_HEIGHT)-1:0] output_y,
   output logic [idx_w(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

   localparam int N_KW    = KERNEL_SIZE * KERNEL_SIZE * INPUT_NB_CHANNELS;
   localparam int KA_W    = idx_w(N_KW);
   localparam int CI_W    = idx_w(INPUT_NB_CHANNELS);
   localparam int K_W     = idx_w(KERNEL_SIZE);
   localparam int X_CW    = idx_w(FEATURE_MAP_WIDTH);
   localparam int Y_CW    = idx_w(FEATURE_MAP_HEIGHT);
   localparam int CH_CW   = idx_w(OUTPUT_NB_CHANNELS);
   localparam int DR_W    = idx_w(MAC_LATENCY);
   localparam int DR_LAST = (MAC_LATENCY > 1) ? MAC_LATENCY - 2 : 0;
   localparam int HALF    = (KERNEL_SIZE - 1) / 2;

   state_t state, state_nxt;
   logic [DR_W-1:0]  drain_cnt;
   logic [KA_W-1:0]  ka_cnt;
   logic [CI_W-1:0]  ci_cnt;
   logic [K_W-1:0]   kx_cnt, ky_cnt;
   logic [X_CW-1:0]  x_cnt;
   logic [Y_CW-1:0]  y_cnt;
   logic [CH_CW-1:0] ch_cnt;
   logic ka_wrap, ci_wrap, kx_wrap, ky_wrap, x_wrap, y_wrap, ch_wrap;
   logic in_load, in_tap, in_out, tap_pad, tap_adv;
   int   ix_sum, iy_sum;

   assign in_load = (state == LOAD_K);
   assign in_tap  = (state == TAP);
   assign in_out  = (state == OUT);

   // A tap is padding when the shifted coordinate lands outside the map; compared without subtraction.
   always_comb begin
      ix_sum  = int'(x_cnt) + int'(kx_cnt);
      iy_sum  = int'(y_cnt) + int'(ky_cnt);
      tap_pad = (ix_sum < HALF) || (ix_sum >= FEATURE_MAP_WIDTH + HALF) ||
                (iy_sum < HALF) || (iy_sum >= FEATURE_MAP_HEIGHT + HALF);
   end

   // Pad taps advance on their own; in-range taps wait for a data word.
   assign tap_adv      = in_tap & (tap_pad | con_valid);
   assign k_we         = in_load & con_valid;
   assign last_load_K  = in_load & ka_wrap;
   assign con_ready    = in_load | (in_tap & ~tap_pad);
   assign k_addr       = (in_load | in_tap) ? ka_cnt : '0;
   assign mac_valid    = tap_adv;
   assign mac_clear    = tap_adv & (ky_cnt == '0) & (kx_cnt == '0) & (ci_cnt == '0);
   assign pad          = in_tap & tap_pad;
   assign output_x     = output_valid ? x_cnt : '0;
   assign output_y     = output_valid ? y_cnt : '0;
   assign output_ch    = output_valid ? ch_cnt : '0;

   // Linear kernel address doubles as write pointer during load and tap read pointer (ky, kx, ci order).
   conv_idx_counter #(.N(N_KW), .W(KA_W)) u_ka (
      .clk(clk), .arst_n_in(arst_n_in), .clr(1'b0), .en(k_we | tap_adv), .cnt(ka_cnt), .wrap(ka_wrap));
   conv_idx_counter #(.N(INPUT_NB_CHANNELS), .W(CI_W)) u_ci (
      .clk(clk), .arst_n_in(arst_n_in), .clr(1'b0), .en(tap_adv), .cnt(ci_cnt), .wrap(ci_wrap));
   conv_idx_counter #(.N(KERNEL_SIZE), .W(K_W)) u_kx (
      .clk(clk), .arst_n_in(arst_n_in), .clr(1'b0), .en(ci_wrap), .cnt(kx_cnt), .wrap(kx_wrap));
   conv_idx_counter #(.N(KERNEL_SIZE), .W(K_W)) u_ky (
      .clk(clk), .arst_n_in(arst_n_in), .clr(1'b0), .en(kx_wrap), .cnt(ky_cnt), .wrap(ky_wrap));
   conv_idx_counter #(.N(FEATURE_MAP_WIDTH), .W(X_CW)) u_x (
      .clk(clk), .arst_n_in(arst_n_in), .clr(last_load_K), .en(in_out), .cnt(x_cnt), .wrap(x_wrap));
   conv_idx_counter #(.N(FEATURE_MAP_HEIGHT), .W(Y_CW)) u_y (
      .clk(clk), .arst_n_in(arst_n_in), .clr(last_load_K), .en(x_wrap), .cnt(y_cnt), .wrap(y_wrap));
   conv_idx_counter #(.N(OUTPUT_NB_CHANNELS), .W(CH_CW)) u_ch (
      .clk(clk), .arst_n_in(arst_n_in), .clr(1'b0), .en(y_wrap), .cnt(ch_cnt), .wrap(ch_wrap));

   // Next-state selection; the loop counters' wrap flags mark the end of each nesting level.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = LOAD_K;
         LOAD_K:  if (ka_wrap) state_nxt = TAP;
         TAP:     if (ky_wrap) state_nxt = (MAC_LATENCY > 1) ? DRAIN : OUT;
         DRAIN:   if (drain_cnt == DR_W'(DR_LAST)) state_nxt = OUT;
         OUT:     state_nxt = ch_wrap ? DONE : (y_wrap ? LOAD_K : TAP);
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered status outputs taken from the next state.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state        <= IDLE;
         drain_cnt    <= '0;
         running      <= 1'b0;
         output_valid <= 1'b0;
         driving_cons <= 1'b0;
      end else begin
         state        <= state_nxt;
         drain_cnt    <= (state == DRAIN) ? drain_cnt + DR_W'(1) : '0;
         running      <= (state_nxt != IDLE);
         output_valid <= (state_nxt == OUT);
         driving_cons <= (state_nxt == OUT);
      end
   end

endmodule
